// File: rtl/if_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// Entry layout and the NOP word that decode sees when the head is empty.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam fetch_entry_t NOP_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR, adel: 1'b0};

endpackage

// File: rtl/ifb_ptr_ctrl.sv
// Read/write pointers, occupancy count and flush handling for if_instr_buffer.
// Produces full/empty status and the gated storage write enable.
module ifb_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    input  logic             bypass_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, empty, wr_en, rd_en;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Push is refused when full even if the head pops this cycle; flush wins over both.
    assign wr_en = push_req_i & ~full & ~bypass_i & ~flush_i;
    assign rd_en = pop_req_i & ~empty & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o   = full;
    assign empty_o  = empty;
    assign wr_en_o  = wr_en;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/if_instr_buffer.sv
// Fetch-to-decode decoupling queue holding {pc, instr, adel} entries.
// Optional IFB_BYPASS_EN: empty buffer forwards an unstalled fetch word to decode in the same cycle.
module if_instr_buffer
    import if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_i,
    input  logic [31:0]      if_instr_i,
    input  logic             if_adel_i,
    output logic             if_ready_o,
    input  logic             id_stall_i,
    output logic             id_valid_o,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_instr_o,
    output logic             id_adel_o,
    output logic [PTR_W:0]   count_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    fetch_entry_t     in_entry;
    fetch_entry_t     head;
    logic             full, empty, wr_en, bypass, head_valid;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign in_entry = '{pc: if_pc_i, instr: if_instr_i, adel: if_adel_i};

`ifdef IFB_BYPASS_EN
    assign bypass = empty & if_valid_i & ~id_stall_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    ifb_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .push_req_i (if_valid_i),
        .pop_req_i  (~id_stall_i),
        .bypass_i   (bypass),
        .full_o     (full),
        .empty_o    (empty),
        .wr_en_o    (wr_en),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count_o)
    );

    // Storage is deliberately unreset; only the pointers and count define validity.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_ptr] = in_entry;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        head       = NOP_ENTRY;
        head_valid = 1'b0;
        if (bypass) begin
            head       = in_entry;
            head_valid = 1'b1;
        end else if (!empty) begin
            head       = mem_q[rd_ptr];
            head_valid = 1'b1;
        end
    end

    assign if_ready_o = ~full;
    assign id_valid_o = head_valid;
    assign id_pc_o    = head.pc;
    assign id_instr_o = head.instr;
    assign id_adel_o  = head.adel;

endmodule

// File: tb/tb_if_instr_buffer.sv
// Directed self-checking bench for if_instr_buffer (DEPTH=4); follows IFB_BYPASS_EN if defined.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later, well before the next edge.
module tb_if_instr_buffer;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_instr_i;
    logic        if_adel_i;
    logic        if_ready_o;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_adel_o;
    logic [2:0]  count_o;

    int vectors     = 0;
    int miscompares = 0;

    if_instr_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_instr_i (if_instr_i),
        .if_adel_i  (if_adel_i),
        .if_ready_o (if_ready_o),
        .id_stall_i (id_stall_i),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_instr_o (id_instr_o),
        .id_adel_o  (id_adel_o),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic adel, input logic stall, input logic flush);
        if_valid_i = valid;
        if_pc_i    = pc;
        if_instr_i = instr;
        if_adel_i  = adel;
        id_stall_i = stall;
        flush_i    = flush;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic adel, input logic [2:0] cnt);
        checkOutput({tag, " valid"}, id_valid_o, 1);
        checkOutput({tag, " pc"},    id_pc_o,    pc);
        checkOutput({tag, " instr"}, id_instr_o, instr);
        checkOutput({tag, " adel"},  id_adel_o,  adel);
        checkOutput({tag, " count"}, count_o,    cnt);
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, " valid"}, id_valid_o, 0);
        checkOutput({tag, " pc"},    id_pc_o,    0);
        checkOutput({tag, " instr"}, id_instr_o, 0);
        checkOutput({tag, " adel"},  id_adel_o,  0);
        checkOutput({tag, " count"}, count_o,    0);
    endtask

    initial begin
        rst = 1'b1;
        if_valid_i = 1'b0; if_pc_i = '0; if_instr_i = '0; if_adel_i = 1'b0;
        id_stall_i = 1'b0; flush_i = 1'b0;
        #2;
        checkEmpty("reset");
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("reset if_ready", if_ready_o, 1);

        // 1: single push (stalled so bypass cannot claim it), visible next cycle, then popped
        applyStimulus(1, 32'hBFC0_0000, 32'h3C08_0001, 0, 1, 0);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        checkHead("t1 head", 32'hBFC0_0000, 32'h3C08_0001, 0, 3'd1);
        step();
        checkEmpty("t1 popped");

        // 2: fill under stall, 5th word dropped, drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), (i == 2), 1, 0);
            step();
        end
        applyStimulus(1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1, 1, 0);
        checkOutput("t2 full count", count_o, 4);
        checkOutput("t2 full if_ready", if_ready_o, 0);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkHead($sformatf("t2 drain%0d", i), 32'h100 + 32'(4 * i), 32'h1000 + 32'(i),
                      (i == 2), 3'(4 - i));
            step();
        end
        checkEmpty("t2 drained");

        // 3: full buffer with push+pop in the same cycle -> push refused
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 0, 1, 0);
            step();
        end
        applyStimulus(1, 32'hAAAA_0000, 32'hAAAA_AAAA, 0, 0, 0);
        checkOutput("t3 if_ready", if_ready_o, 0);
        checkHead("t3 before", 32'h200, 32'h2000, 0, 3'd4);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 1, 0);
        checkHead("t3 after", 32'h204, 32'h2001, 0, 3'd3);

        // 4: flush with a word offered at count 3
        applyStimulus(1, 32'hF1F1_0000, 32'hF1F1_F1F1, 1, 0, 1);
        checkOutput("t4 pre count", count_o, 3);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        checkEmpty("t4 flushed");
        step();
        checkEmpty("t4 settled");

        // 5: one resident entry, then 10 cycles of simultaneous push/pop across pointer wrap
        applyStimulus(1, 32'h300, 32'h3000, 0, 1, 0);
        step();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 0, 0, 0);
            checkHead($sformatf("t5 stream%0d", i), 32'h300 + 32'(4 * (i - 1)), 32'h3000 + 32'(i - 1),
                      0, 3'd1);
            step();
        end
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        checkHead("t5 last", 32'h328, 32'h300A, 0, 3'd1);
        step();
        checkEmpty("t5 drained");

        // 6: empty buffer, unstalled push
        applyStimulus(1, 32'h400, 32'h2402_0005, 0, 0, 0);
`ifdef IFB_BYPASS_EN
        checkOutput("t6 bypass valid", id_valid_o, 1);
        checkOutput("t6 bypass instr", id_instr_o, 32'h2402_0005);
        checkOutput("t6 bypass count", count_o, 0);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        checkEmpty("t6 after bypass");
`else
        checkOutput("t6 same-cycle valid", id_valid_o, 0);
        checkOutput("t6 same-cycle instr", id_instr_o, 0);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
        checkHead("t6 next", 32'h400, 32'h2402_0005, 0, 3'd1);
        step();
        checkEmpty("t6 popped");
`endif

        // 7: asynchronous reset with two entries held
        applyStimulus(1, 32'h500, 32'h5000, 0, 1, 0);
        step();
        applyStimulus(1, 32'h504, 32'h5001, 0, 1, 0);
        step();
        applyStimulus(0, 32'h0, 32'h0, 0, 1, 0);
        checkHead("t7 held", 32'h500, 32'h5000, 0, 3'd2);
        rst = 1'b1;
        #1;
        checkEmpty("t7 async reset");
        step();
        rst = 1'b0;
        #1;
        checkOutput("t7 if_ready", if_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
